// File: rtl/radix_agu_param_if.sv
// rtl/radix_agu_param_if.sv - handshake and address bus of the radix AGU
// Purpose: groups the controller handshake (start/en/abort/busy/done) and the
//   registered address outputs into one bundle.
// Ports (slave = AGU side):
//   start, en, abort        controller -> AGU
//   busy, done, addr_valid  AGU -> controller
//   BN_out, MA, ROMA, stage_out, last_stage, RDC_sel_out, DTFAG_digits
//                           AGU -> datapath / twiddle generator
interface radix_agu_param_if #(
  parameter int RADIX_LOG2 = 4,
  parameter int NUM_STAGES = 4
);
  localparam int BC_WIDTH   = RADIX_LOG2 * (NUM_STAGES - 1);
  localparam int SC_WIDTH   = $clog2(NUM_STAGES);
  localparam int A_WIDTH    = BC_WIDTH - 1;
  localparam int ROMA_WIDTH = BC_WIDTH;
  localparam int DG_WIDTH   = RADIX_LOG2 * (NUM_STAGES - 1);

  logic                  start;
  logic                  en;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic                  addr_valid;
  logic                  BN_out;
  logic [A_WIDTH-1:0]    MA;
  logic [ROMA_WIDTH-1:0] ROMA;
  logic [SC_WIDTH-1:0]   stage_out;
  logic                  last_stage;
  logic [RADIX_LOG2-1:0] RDC_sel_out;
  logic [DG_WIDTH-1:0]   DTFAG_digits;

  modport master (
    output start, en, abort,
    input  busy, done, addr_valid, BN_out, MA, ROMA, stage_out, last_stage,
           RDC_sel_out, DTFAG_digits
  );

  modport slave (
    input  start, en, abort,
    output busy, done, addr_valid, BN_out, MA, ROMA, stage_out, last_stage,
           RDC_sel_out, DTFAG_digits
  );
endinterface

// File: rtl/radix_agu_param.sv
// rtl/radix_agu_param.sv - parametrised conflict-free NTT address generation unit
// Purpose: walks a butterfly counter through every stage of an
//   N = 2^(RADIX_LOG2*NUM_STAGES)-point transform and emits, per enabled cycle,
//   bank bit, bank address, twiddle ROM address and reduction select, plus
//   DTFAG digit counters for the twiddle generator.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    radix_agu_param_if.slave (handshake in, registered addresses out)
module radix_agu_param #(
  parameter int RADIX_LOG2 = 4,
  parameter int NUM_STAGES = 4,
  parameter int GROUP_LOG2 = 2
) (
  input logic            clk,
  input logic            rst_n,
  radix_agu_param_if.slave bus
);
  localparam int BC_WIDTH   = RADIX_LOG2 * (NUM_STAGES - 1);
  localparam int SC_WIDTH   = $clog2(NUM_STAGES);
  localparam int A_WIDTH    = BC_WIDTH - 1;
  localparam int ROMA_WIDTH = BC_WIDTH;
  localparam int DG_WIDTH   = RADIX_LOG2 * (NUM_STAGES - 1);
  localparam int ROT_WIDTH  = $clog2(BC_WIDTH) + 1;
  localparam logic [SC_WIDTH-1:0] LAST_STAGE = SC_WIDTH'(NUM_STAGES - 1);

  // DRAIN holds busy for the one cycle in which the final address is on the
  // outputs, so busy falls together with the done pulse.
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  logic [BC_WIDTH-1:0]   bc;
  logic [SC_WIDTH-1:0]   stage;
  logic [GROUP_LOG2-1:0] sub;
  logic [DG_WIDTH-1:0]   digits;

  logic                  busy_q;
  logic                  done_q;
  logic                  valid_q;
  logic                  bn_q;
  logic [A_WIDTH-1:0]    ma_q;
  logic [ROMA_WIDTH-1:0] roma_q;
  logic [SC_WIDTH-1:0]   stage_q;
  logic                  last_q;
  logic [RADIX_LOG2-1:0] rdc_q;

  logic                  is_last;
  logic [ROT_WIDTH-1:0]  rot;
  logic [BC_WIDTH-1:0]   bc_rr;
  logic [ROMA_WIDTH-1:0] roma_c;

  assign is_last = (stage == LAST_STAGE);

  always_comb begin
    rot    = is_last ? '0 : ROT_WIDTH'(stage) * ROT_WIDTH'(RADIX_LOG2);
    // Rotate right: low half of the doubled word shifted right by rot.
    bc_rr  = BC_WIDTH'({bc, bc} >> rot);
    roma_c = is_last ? '0 : ROMA_WIDTH'(bc_rr << rot);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bc      <= '0;
      stage   <= '0;
      sub     <= '0;
      digits  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      bn_q    <= 1'b0;
      ma_q    <= '0;
      roma_q  <= '0;
      stage_q <= '0;
      last_q  <= 1'b0;
      rdc_q   <= '0;
    end else begin
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          // abort beats a coincident start
          if (bus.start && !bus.abort) begin
            state  <= RUN;
            busy_q <= 1'b1;
            bc     <= '0;
            stage  <= '0;
            sub    <= '0;
            digits <= '0;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            bc     <= '0;
            stage  <= '0;
            sub    <= '0;
            digits <= '0;
          end else if (bus.en) begin
            valid_q <= 1'b1;
            bn_q    <= ^bc_rr;
            ma_q    <= bc_rr[BC_WIDTH-1:1];
            roma_q  <= roma_c;
            stage_q <= stage;
            last_q  <= is_last;
            rdc_q   <= bc[RADIX_LOG2-1:0];
            bc      <= bc + 1'b1;
            if (&bc) begin
              if (is_last) begin
                state <= DRAIN;
                stage <= '0;
              end else begin
                stage <= stage + 1'b1;
              end
            end
            sub <= sub + 1'b1;
            // All digits share radix 2^RADIX_LOG2, so a plain binary increment
            // of the packed vector is exactly the digit-to-digit carry chain.
            if (&sub) digits <= digits + 1'b1;
          end
        end
        DRAIN: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= !bus.abort;
          if (bus.abort) begin
            sub    <= '0;
            digits <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.addr_valid   = valid_q;
  assign bus.BN_out       = bn_q;
  assign bus.MA           = ma_q;
  assign bus.ROMA         = roma_q;
  assign bus.stage_out    = stage_q;
  assign bus.last_stage   = last_q;
  assign bus.RDC_sel_out  = rdc_q;
  assign bus.DTFAG_digits = digits;
endmodule

// File: tb/tb_radix_agu_param.sv
// tb/tb_radix_agu_param.sv - self-checking bench for radix_agu_param
module tb_radix_agu_param;
  localparam int R = 4;
  localparam int S = 4;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  radix_agu_param_if #(.RADIX_LOG2(R), .NUM_STAGES(S)) bus ();

  radix_agu_param #(.RADIX_LOG2(R), .NUM_STAGES(S), .GROUP_LOG2(G)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        bn;
    logic [10:0] ma;
    logic [11:0] roma;
    logic [1:0]  stg;
    logic        last;
    logic [3:0]  rdc;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  exp_t obs;
  int   total = 0;
  int   bad = 0;
  int   m_state = 0;
  int   m_bc = 0;
  int   m_stage = 0;
  int   m_n = 0;
  logic e_valid, e_done, e_busy;
  int   valid_cnt = 0;
  int   done_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  function automatic exp_t calc(input int bc, input int stg);
    exp_t       x;
    logic [11:0] b;
    logic [11:0] rr;
    int         rot;
    b   = 12'(bc);
    rot = (stg == S - 1) ? 0 : stg * R;
    for (int i = 0; i < 12; i++) rr[i] = b[(i + rot) % 12];
    x.bn   = ^rr;
    x.ma   = rr[11:1];
    x.roma = (stg == S - 1) ? 12'h0 : 12'(rr << rot);
    x.stg  = 2'(stg);
    x.last = (stg == S - 1);
    x.rdc  = b[3:0];
    return x;
  endfunction

  task automatic cyc(input logic e, input logic s = 1'b0, input logic a = 1'b0);
    exp_t got;
    bus.en = e;
    bus.start = s;
    bus.abort = a;
    e_valid = 1'b0;
    e_done = 1'b0;
    case (m_state)
      0: if (s && !a) begin
        m_state = 1; m_bc = 0; m_stage = 0; m_n = 0;
      end
      1: if (a) begin
        m_state = 0; m_bc = 0; m_stage = 0; m_n = 0;
      end else if (e) begin
        last_exp = calc(m_bc, m_stage);
        sb.push_back(last_exp);
        e_valid = 1'b1;
        m_n++;
        if (m_bc == 4095) begin
          m_bc = 0;
          if (m_stage == S - 1) begin
            m_stage = 0;
            m_state = 2;
          end else begin
            m_stage++;
          end
        end else begin
          m_bc++;
        end
      end
      default: begin
        m_state = 0;
        e_done = !a;
        if (a) m_n = 0;
      end
    endcase
    e_busy = (m_state != 0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("addr_valid", bus.addr_valid, e_valid);
    chk("busy", bus.busy, e_busy);
    chk("done", bus.done, e_done);
    chk("digits", bus.DTFAG_digits, 64'((m_n >> G) & 12'hFFF));
    obs = {bus.BN_out, bus.MA, bus.ROMA, bus.stage_out, bus.last_stage, bus.RDC_sel_out};
    if (bus.addr_valid) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        got = sb.pop_front();
        chk("addr_fields", obs, got);
      end
    end else begin
      chk("hold_fields", obs, last_exp);
    end
    if (bus.done) done_cnt++;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.en = 1'b0;
    bus.abort = 1'b0;
    last_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        {bus.busy, bus.done, bus.addr_valid, bus.BN_out, bus.MA, bus.ROMA,
         bus.stage_out, bus.last_stage, bus.RDC_sel_out, bus.DTFAG_digits}, 64'd0);
    rst_n = 1'b1;
    cyc(1'b1);
    cyc(1'b1);

    // Full run with an early stall pattern and an ignored start
    valid_cnt = 0;
    done_cnt = 0;
    cyc(1'b1, 1'b1);
    cyc(1'b1);
    chk("v1_bn_ma_roma", {bus.BN_out, bus.MA, bus.ROMA}, 64'd0);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
    chk("v2_bn", bus.BN_out, 64'd1);
    chk("v2_ma", bus.MA, 64'd0);
    chk("v2_roma", bus.ROMA, 64'h001);
    chk("v2_rdc", bus.RDC_sel_out, 64'd1);
    cyc(1'b1);
    cyc(1'b1);
    chk("digits_after_4", bus.DTFAG_digits, 64'h001);
    for (int i = 0; i < 60; i++) cyc(1'b1, i == 10);
    chk("digits_after_64", bus.DTFAG_digits, 64'h010);
    for (int i = 0; i < 20000 && !bus.done; i++) begin
      cyc(1'b1);
      if (bus.addr_valid && valid_cnt == 4115) begin
        chk("s1_ma", bus.MA, 64'h100);
        chk("s1_bn", bus.BN_out, 64'd0);
        chk("s1_roma", bus.ROMA, 64'h010);
        chk("s1_stage", bus.stage_out, 64'd1);
      end
      if (bus.addr_valid && valid_cnt == 12307) begin
        chk("s3_ma", bus.MA, 64'h009);
        chk("s3_roma", bus.ROMA, 64'd0);
        chk("s3_last", bus.last_stage, 64'd1);
      end
    end
    chk("valid_count", 64'(valid_cnt), 64'd16384);
    chk("end_busy", bus.busy, 64'd0);
    chk("end_digits", bus.DTFAG_digits, 64'd0);
    repeat (3) cyc(1'b1);
    chk("done_count", 64'(done_cnt), 64'd1);

    // Abort at valid #100, then restart
    valid_cnt = 0;
    done_cnt = 0;
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 300 && valid_cnt < 100; i++) cyc(1'b1);
    chk("pre_abort_count", 64'(valid_cnt), 64'd100);
    cyc(1'b1, 1'b0, 1'b1);
    chk("abort_busy", bus.busy, 64'd0);
    repeat (4) cyc(1'b1);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    cyc(1'b1, 1'b1);
    cyc(1'b1);
    chk("restart_stage", bus.stage_out, 64'd0);
    chk("restart_rdc_ma", {bus.RDC_sel_out, bus.MA}, 64'd0);
    repeat (50) cyc(1'b1);

    // Asynchronous reset mid-run
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs",
        {bus.busy, bus.done, bus.addr_valid, bus.BN_out, bus.MA, bus.ROMA,
         bus.stage_out, bus.last_stage, bus.RDC_sel_out, bus.DTFAG_digits}, 64'd0);
    m_state = 0; m_bc = 0; m_stage = 0; m_n = 0;
    last_exp = '0;
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) cyc(1'b1);

    // start coincident with abort in IDLE stays idle
    cyc(1'b1, 1'b1, 1'b1);
    chk("start_abort_idle", bus.busy, 64'd0);
    repeat (3) cyc(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
